alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the 4-bit combinational ALU. It executes ADD, SUB,
//  CMP, SHL, SHR, MUL, AND and OR on WIDTH-bit operands with a 2*WIDTH-bit registered result.
//  MUL is a multi-cycle shift-add engine. All other ops complete in one cycle.

---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ADD/SUB/CMP/SHL/SHR/AND/OR plus a
// shift-add multiplier that retires one multiplier bit per clock.
module alu_seq #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out,
   output logic                 cout,
   output logic                 zero
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_CMP = 3'b010;
   localparam logic [2:0] OP_SHL = 3'b011;
   localparam logic [2:0] OP_SHR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_AND = 3'b110;
   localparam logic [2:0] OP_OR  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              w_accept;

   logic [RW-1:0]     r_out;
   logic              r_cout;

   logic [RW-1:0]     r_mcand;
   logic [WIDTH-1:0]  r_mplier;
   logic [RW-1:0]     r_acc;
   logic [CW-1:0]     r_cnt;
   logic [RW-1:0]     w_acc_next;
   logic              w_mul_last;

   logic [WIDTH:0]    w_sum;
   logic [WIDTH:0]    w_diff;
   logic [RW-1:0]     w_a_zext;
   logic [RW-1:0]     w_a_sext;
   logic              w_shift_big;
   logic [RW-1:0]     w_result;
   logic              w_cout;

   // ---------------------------------------------------------------
   // Single-cycle datapath, evaluated directly on the input operands
   // ---------------------------------------------------------------
   assign w_sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   // The (WIDTH+1)-bit difference never wraps, so its MSB is the borrow.
   assign w_diff      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
   assign w_a_zext    = {{WIDTH{1'b0}}, a};
   assign w_a_sext    = {{WIDTH{a[WIDTH-1]}}, a};
   assign w_shift_big = (32'(b) >= 32'(RW));

   always_comb begin
      w_result = '0;
      w_cout   = 1'b0;
      case (op)
         OP_ADD: begin
            w_result = RW'(w_sum[WIDTH-1:0]);
            w_cout   = w_sum[WIDTH];
         end
         OP_SUB: begin
            w_result = RW'(w_diff[WIDTH-1:0]);
            w_cout   = w_diff[WIDTH];
         end
         OP_CMP: begin
            if (a < b) begin
               w_result = RW'(2);
            end else if (a > b) begin
               w_result = RW'(1);
            end else begin
               w_result = '0;
            end
         end
         OP_SHL: begin
            w_result = w_shift_big ? '0 : (w_a_zext << b);
         end
         OP_SHR: begin
            if (cin) begin
               w_result = w_shift_big ? {RW{a[WIDTH-1]}}
                                      : $unsigned($signed(w_a_sext) >>> b);
            end else begin
               w_result = w_shift_big ? '0 : (w_a_zext >> b);
            end
         end
         OP_AND: begin
            w_result = RW'(a & b);
         end
         OP_OR: begin
            w_result = RW'(a | b);
         end
         default: begin
            w_result = '0;
            w_cout   = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Shift-add multiplier step: multiplier consumed LSB first
   // ---------------------------------------------------------------
   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mul_last = (r_cnt == LAST_ITER);

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   assign w_accept = in_valid && (r_state == S_IDLE);

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_next = (op == OP_MUL) ? S_MUL : S_DONE;
            end
         end
         S_MUL: begin
            if (w_mul_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_out    <= '0;
         r_cout   <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            if (op == OP_MUL) begin
               r_mcand  <= w_a_zext;
               r_mplier <= b;
               r_acc    <= '0;
               r_cnt    <= '0;
            end else begin
               r_out  <= w_result;
               r_cout <= w_cout;
            end
         end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            // out keeps the previous result until the final partial sum lands
            if (w_mul_last) begin
               r_out  <= w_acc_next;
               r_cout <= 1'b0;
            end
         end
      end
   end

   assign out  = r_out;
   assign cout = r_cout;
   assign zero = (r_out == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomized scoreboard bench for alu_seq at WIDTH=4.
module tb_alu_seq;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [2:0]     op;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           cin;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] out;
   logic           cout;
   logic           zero;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .cout      (cout),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] res;
      logic       co;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference arithmetic in plain integers.
   function automatic exp_t model(input logic [2:0] o, input int x, input int y,
                                  input int c, input string tag);
      exp_t e;
      int   r;
      int   sa;
      e.res = 8'h00;
      e.co  = 1'b0;
      e.tag = tag;
      case (o)
         3'd0: begin
            r     = x + y + c;
            e.res = 8'(r & 15);
            e.co  = 1'((r >> 4) & 1);
         end
         3'd1: begin
            r     = x - y - c;
            e.res = 8'(r & 15);
            e.co  = (x < y + c);
         end
         3'd2: e.res = (x < y) ? 8'd2 : ((x > y) ? 8'd1 : 8'd0);
         3'd3: e.res = (y >= 8) ? 8'd0 : 8'((x << y) & 255);
         3'd4: begin
            if (c != 0) begin
               sa    = (x >= 8) ? x - 16 : x;
               r     = (y >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> y);
               e.res = 8'(r & 255);
            end else begin
               e.res = (y >= 8) ? 8'd0 : 8'(x >> y);
            end
         end
         3'd5: e.res = 8'(x * y);
         3'd6: e.res = 8'(x & y);
         default: e.res = 8'(x | y);
      endcase
      return e;
   endfunction

   // Present one op, push its expectation, then scramble the inputs after acceptance.
   task automatic send(input logic [2:0] o, input int x, input int y, input int c, input exp_t e);
      @(negedge clk);
      chk({e.tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      op       = o;
      a        = 4'(x);
      b        = 4'(y);
      cin      = 1'(c);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      op       = 3'($urandom);
      a        = 4'($urandom);
      b        = 4'($urandom);
      cin      = 1'($urandom);
   endtask

   // Wait for the result, check it against the scoreboard, optionally stall the consumer.
   task automatic collect(input string tag, input int exp_lat, input int hold, input bit poke);
      int         lat;
      exp_t       e;
      logic [7:0] o_s;
      logic       c_s;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         chk({tag, "/busy_in_ready"}, 32'(in_ready), 32'd0);
         @(negedge clk);
         lat++;
      end
      chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "/sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "/out"}, 32'(out), 32'(e.res));
         chk({tag, "/cout"}, 32'(cout), 32'(e.co));
         chk({tag, "/zero"}, 32'(zero), 32'(e.res == 8'h00));
      end
      o_s = out;
      c_s = cout;
      for (int i = 0; i < hold; i++) begin
         if (poke && i == 0) begin
            in_valid = 1'b1;
            op       = 3'd0;
            a        = 4'd1;
            b        = 4'd1;
            cin      = 1'b0;
         end
         @(negedge clk);
         chk({tag, "/hold_out"}, 32'(out), 32'(o_s));
         chk({tag, "/hold_cout"}, 32'(cout), 32'(c_s));
         chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "/drain_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "/drain_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "/idle_out_held"}, 32'(out), 32'(o_s));
      $display("txn %s: out=%02h cout=%0b latency=%0d", tag, out, cout, lat);
   endtask

   task automatic run(input string tag, input logic [2:0] o, input int x, input int y,
                      input int c, input logic [7:0] res, input logic co, input int hold);
      exp_t e;
      e.res = res;
      e.co  = co;
      e.tag = tag;
      send(o, x, y, c, e);
      collect(tag, (o == 3'd5) ? 5 : 1, hold, 1'b0);
   endtask

   initial begin
      exp_t e;
      logic [2:0] ro;
      int ra;
      int rb;
      int rc;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 3'd0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset/in_ready", 32'(in_ready), 32'd1);
      chk("reset/out_valid", 32'(out_valid), 32'd0);
      chk("reset/out", 32'(out), 32'd0);
      chk("reset/cout", 32'(cout), 32'd0);
      chk("reset/zero", 32'(zero), 32'd1);

      // ADD with carry, backpressure and a refused second op
      e.res = 8'h01;
      e.co  = 1'b1;
      e.tag = "add_F_1_c1";
      send(3'd0, 15, 1, 1, e);
      collect("add_F_1_c1", 1, 3, 1'b1);
      @(negedge clk);
      chk("add/no_queued_op", 32'(out_valid), 32'd0);
      chk("add/no_queued_sb", 32'(sb.size()), 32'd0);

      run("sub_3_5",   3'd1, 3, 5, 0, 8'h0E, 1'b1, 3);
      run("cmp_2_3",   3'd2, 2, 3, 0, 8'h02, 1'b0, 0);
      run("cmp_7_7",   3'd2, 7, 7, 0, 8'h00, 1'b0, 0);
      run("mul_F_F",   3'd5, 15, 15, 0, 8'hE1, 1'b0, 0);
      run("mul_0_9",   3'd5, 0, 9, 0, 8'h00, 1'b0, 0);
      run("shr_8_1_a", 3'd4, 8, 1, 1, 8'hFC, 1'b0, 0);
      run("shr_8_1_l", 3'd4, 8, 1, 0, 8'h04, 1'b0, 0);
      run("shr_8_9_a", 3'd4, 8, 9, 1, 8'hFF, 1'b0, 0);
      run("shl_1_8",   3'd3, 1, 8, 0, 8'h00, 1'b0, 0);
      run("shl_9_3",   3'd3, 9, 3, 0, 8'h48, 1'b0, 0);

      // Reset sampled at the second MUL iteration edge
      @(negedge clk);
      in_valid = 1'b1;
      op       = 3'd5;
      a        = 4'd7;
      b        = 4'd5;
      cin      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mulrst/out_valid", 32'(out_valid), 32'd0);
      chk("mulrst/in_ready", 32'(in_ready), 32'd1);
      chk("mulrst/out", 32'(out), 32'd0);
      chk("mulrst/zero", 32'(zero), 32'd1);
      @(negedge clk);
      chk("mulrst/stays_idle", 32'(out_valid), 32'd0);
      $display("txn mul_reset: out=%02h out_valid=%0b in_ready=%0b", out, out_valid, in_ready);

      run("add_2_3", 3'd0, 2, 3, 0, 8'h05, 1'b0, 0);

      // Randomized ops against the integer model
      for (int i = 0; i < 16; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = int'($urandom_range(0, 15));
         rb = int'($urandom_range(0, 15));
         rc = int'($urandom_range(0, 1));
         e  = model(ro, ra, rb, rc, $sformatf("rnd%0d_op%0d_%0h_%0h_%0d", i, ro, ra, rb, rc));
         send(ro, ra, rb, rc, e);
         collect(e.tag, (ro == 3'd5) ? 5 : 1, i % 3, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
